onehot_split: RTL and testbench

// - Inverse of a row-OR reduction: accepts one COLS-wide mask and emits its set bits one per

---
 rtl/onehot_split_pkg.sv | 7 +
 rtl/onehot_split_lowest_set.sv | 25 ++
 rtl/onehot_split.sv | 93 +++++++++
 tb/tb_onehot_split.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_split_pkg.sv
// Shared constants for the one-hot splitter and its lowest-set-bit picker.
// Kept deliberately small: the FSM encoding stays private to the top module.
package onehot_split_pkg;

  localparam int unsigned OHS_DEFAULT_COLS = 8;

endpackage : onehot_split_pkg

// File: rtl/onehot_split_lowest_set.sv
// Combinational lowest-set-bit picker: isolates the lowest set bit of a mask
// and encodes its position. A zero mask yields a zero one-hot and index 0.
module lowest_set
  import onehot_split_pkg::*;
#(
  parameter  int unsigned COLS = OHS_DEFAULT_COLS,
  localparam int unsigned IDXW = $clog2(COLS)
) (
  input  logic [COLS-1:0] mask,
  output logic [COLS-1:0] onehot,
  output logic [IDXW-1:0] idx
);

  // Two's-complement trick: mask & -mask keeps only the lowest set bit.
  assign onehot = mask & (~mask + COLS'(1));

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (onehot[i]) idx = idx | IDXW'(i);
    end
  end

endmodule : lowest_set

// File: rtl/onehot_split.sv
// Splits a COLS-wide mask into one-hot vectors, lowest index first, one per
// output handshake; the next mask may be accepted on the last handshake.
module onehot_split
  import onehot_split_pkg::*;
#(
  parameter  int unsigned COLS = OHS_DEFAULT_COLS,
  localparam int unsigned IDXW = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [COLS-1:0] InVec,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [COLS-1:0] OutOneHot,
  output logic [IDXW-1:0] OutIdx,
  output logic            OutLast
);

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [COLS-1:0] rem, rem_nxt;
  logic [COLS-1:0] pick_onehot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_last;
  logic            out_fire;
  logic            in_fire;

  lowest_set #(.COLS(COLS)) u_pick (
    .mask   (rem),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign pick_last = (rem & ~pick_onehot) == '0;

  // Outputs are gated by state so IDLE presents all-zero values regardless of rem.
  assign OutValid  = (state == SPLIT);
  assign OutOneHot = OutValid ? pick_onehot : '0;
  assign OutIdx    = OutValid ? pick_idx    : '0;
  assign OutLast   = OutValid & pick_last;

  assign out_fire = OutValid & OutReady;
  assign InReady  = (state == IDLE) | (out_fire & OutLast);
  assign in_fire  = InValid & InReady;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    unique case (state)
      IDLE: begin
        if (in_fire && InVec != '0) begin
          rem_nxt   = InVec;
          state_nxt = SPLIT;
        end
      end
      SPLIT: begin
        if (out_fire) begin
          if (!pick_last) begin
            rem_nxt = rem & ~pick_onehot;
          end else if (in_fire && InVec != '0) begin
            rem_nxt   = InVec;
            state_nxt = SPLIT;
          end else begin
            rem_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        rem_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

endmodule : onehot_split

// File: tb/tb_onehot_split.sv
// Self-checking bench for onehot_split at COLS=8 (dut a) and COLS=5 (dut b),
// with directed scenarios plus a queue-based scoreboard of expected outputs.
module tb_onehot_split;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [7:0] a_in_vec, a_out_onehot;
  logic [2:0] a_out_idx;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [4:0] b_in_vec, b_out_onehot;
  logic [2:0] b_out_idx;

  onehot_split #(.COLS(8)) dut_a (
    .clk(clk), .reset(reset),
    .InValid(a_in_valid), .InReady(a_in_ready), .InVec(a_in_vec),
    .OutValid(a_out_valid), .OutReady(a_out_ready),
    .OutOneHot(a_out_onehot), .OutIdx(a_out_idx), .OutLast(a_out_last)
  );

  onehot_split #(.COLS(5)) dut_b (
    .clk(clk), .reset(reset),
    .InValid(b_in_valid), .InReady(b_in_ready), .InVec(b_in_vec),
    .OutValid(b_out_valid), .OutReady(b_out_ready),
    .OutOneHot(b_out_onehot), .OutIdx(b_out_idx), .OutLast(b_out_last)
  );

  typedef struct {
    logic [7:0] onehot;
    logic [2:0] idx;
    logic       last;
    logic [7:0] mask;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  exp_t       e;
  logic [7:0] or_a, or_b;
  logic [7:0] ob_ext;
  bit         acc_a, acc_b;
  int         checks = 0;
  int         errors = 0;

  // Reference model: walk the mask bit by bit, highest set bit is the last one.
  task automatic push_exp(input logic [7:0] m, input int cols, input bit to_a);
    int   hi;
    exp_t x;
    hi = -1;
    for (int i = 0; i < cols; i++) if (m[i]) hi = i;
    for (int i = 0; i < cols; i++) begin
      if (m[i]) begin
        x.onehot = 8'd1 << i;
        x.idx    = 3'(i);
        x.last   = (i == hi);
        x.mask   = m;
        if (to_a) qa.push_back(x); else qb.push_back(x);
      end
    end
  endtask

  // Sample at the falling edge: pop/compare output handshakes, push accepted inputs.
  task automatic sample();
    @(negedge clk);
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (reset) begin
      qa.delete(); qb.delete();
      or_a = '0;   or_b = '0;
    end else begin
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sb_a_unexpected got idx=%0d onehot=%h, expected no output", a_out_idx, a_out_onehot);
        end else begin
          e = qa.pop_front();
          if (a_out_onehot !== e.onehot || a_out_idx !== e.idx || a_out_last !== e.last) begin
            errors++;
            $display("FAIL sb_a_out got oh=%h idx=%0d last=%b, expected oh=%h idx=%0d last=%b",
                     a_out_onehot, a_out_idx, a_out_last, e.onehot, e.idx, e.last);
          end
          or_a |= a_out_onehot;
          if (e.last) begin
            checks++;
            if (or_a !== e.mask) begin
              errors++;
              $display("FAIL sb_a_or got %h, expected %h", or_a, e.mask);
            end
            or_a = '0;
          end
        end
      end
      if (b_out_valid && b_out_ready) begin
        checks++;
        ob_ext = {3'b000, b_out_onehot};
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL sb_b_unexpected got idx=%0d onehot=%h, expected no output", b_out_idx, ob_ext);
        end else begin
          e = qb.pop_front();
          if (ob_ext !== e.onehot || b_out_idx !== e.idx || b_out_last !== e.last) begin
            errors++;
            $display("FAIL sb_b_out got oh=%h idx=%0d last=%b, expected oh=%h idx=%0d last=%b",
                     ob_ext, b_out_idx, b_out_last, e.onehot, e.idx, e.last);
          end
          or_b |= ob_ext;
          if (e.last) begin
            checks++;
            if (or_b !== e.mask) begin
              errors++;
              $display("FAIL sb_b_or got %h, expected %h", or_b, e.mask);
            end
            or_b = '0;
          end
        end
      end
      if (a_in_valid && a_in_ready) begin
        acc_a = 1'b1;
        push_exp(a_in_vec, 8, 1'b1);
      end
      if (b_in_valid && b_in_ready) begin
        acc_b = 1'b1;
        push_exp({3'b000, b_in_vec}, 5, 1'b0);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_in_valid = 0; a_in_vec = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_vec = '0; b_out_ready = 0;
    repeat (3) begin sample(); advance(); end
    reset = 1'b0;
    sample();
    checks++;
    if ({a_out_valid, a_out_onehot, a_out_idx, a_out_last, a_in_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_a got v=%b oh=%h idx=%0d last=%b rdy=%b, expected 0 00 0 0 1",
               a_out_valid, a_out_onehot, a_out_idx, a_out_last, a_in_ready);
    end
    checks++;
    if ({b_out_valid, b_out_onehot, b_out_idx, b_out_last, b_in_ready} !== {1'b0, 5'h00, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_b got v=%b oh=%h idx=%0d last=%b rdy=%b, expected 0 00 0 0 1",
               b_out_valid, b_out_onehot, b_out_idx, b_out_last, b_in_ready);
    end
    advance();
  endtask

  task automatic test_basic();
    logic [2:0] exp_idx [3];
    exp_idx = '{3'd2, 3'd5, 3'd7};
    a_out_ready = 1; a_in_valid = 1; a_in_vec = 8'hA4;
    sample();
    advance();
    a_in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_idx !== exp_idx[k] || a_out_last !== (k == 2)) begin
        errors++;
        $display("FAIL basic_step%0d got v=%b idx=%0d last=%b, expected v=1 idx=%0d last=%b",
                 k, a_out_valid, a_out_idx, a_out_last, exp_idx[k], (k == 2));
      end
      advance();
    end
    sample();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got v=%b, expected 0", a_out_valid);
    end
    advance();
  endtask

  task automatic test_zero();
    a_out_ready = 1; a_in_valid = 1; a_in_vec = 8'h00;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_cyc%0d got rdy=%b v=%b, expected rdy=1 v=0", k, a_in_ready, a_out_valid);
      end
      advance();
    end
    a_in_valid = 0;
  endtask

  task automatic test_stall();
    a_out_ready = 0; a_in_valid = 1; a_in_vec = 8'h81;
    sample();
    advance();
    a_in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h01 || a_out_idx !== 3'd0 ||
          a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cyc%0d got v=%b oh=%h idx=%0d last=%b rdy=%b, expected 1 01 0 0 0",
                 k, a_out_valid, a_out_onehot, a_out_idx, a_out_last, a_in_ready);
      end
      advance();
    end
    a_out_ready = 1;
    sample();
    checks++;
    if (a_out_onehot !== 8'h01 || a_out_last !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got oh=%h last=%b, expected 01 0", a_out_onehot, a_out_last);
    end
    advance();
    sample();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h80 || a_out_idx !== 3'd7 || a_out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_top got v=%b oh=%h idx=%0d last=%b, expected 1 80 7 1",
               a_out_valid, a_out_onehot, a_out_idx, a_out_last);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic       exp_v   [5];
    logic [2:0] exp_idx [5];
    logic       exp_rdy [5];
    exp_v   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_idx = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd0};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    a_out_ready = 1; a_in_valid = 1; a_in_vec = 8'h10;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++;
      if (a_out_valid !== exp_v[k] || a_out_idx !== exp_idx[k] || a_in_ready !== exp_rdy[k]) begin
        errors++;
        $display("FAIL b2b_cyc%0d got v=%b idx=%0d rdy=%b, expected v=%b idx=%0d rdy=%b",
                 k, a_out_valid, a_out_idx, a_in_ready, exp_v[k], exp_idx[k], exp_rdy[k]);
      end
      advance();
      if (k == 0) a_in_vec = 8'h03;
      if (k == 1) a_in_valid = 0;
    end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1; a_in_valid = 1; a_in_vec = 8'hFF;
    sample();
    advance();
    a_in_valid = 0;
    repeat (3) begin sample(); advance(); end
    reset = 1;
    sample();
    advance();
    reset = 0;
    a_in_valid = 1; a_in_vec = 8'h02;
    sample();
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state got v=%b rdy=%b, expected v=0 rdy=1", a_out_valid, a_in_ready);
    end
    advance();
    a_in_valid = 0;
    sample();
    checks++;
    if (a_out_valid !== 1'b1 || a_out_idx !== 3'd1 || a_out_last !== 1'b1) begin
      errors++;
      $display("FAIL midreset_next got v=%b idx=%0d last=%b, expected 1 1 1", a_out_valid, a_out_idx, a_out_last);
    end
    advance();
    sample();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle got v=%b, expected 0", a_out_valid);
    end
    advance();
  endtask

  task automatic test_random();
    int sent_a, sent_b, budget;
    sent_a = 0; sent_b = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!a_in_valid && sent_a < 25) begin
        a_in_valid = 1; a_in_vec = 8'($urandom); sent_a++;
      end
      if (!b_in_valid && sent_b < 25) begin
        b_in_valid = 1; b_in_vec = 5'($urandom); sent_b++;
      end
      a_out_ready = ($urandom_range(0, 9) < 7);
      b_out_ready = ($urandom_range(0, 9) < 7);
      sample();
      advance();
      if (acc_a) a_in_valid = 0;
      if (acc_b) b_in_valid = 0;
      if (sent_a == 25 && sent_b == 25 && !a_in_valid && !b_in_valid) break;
    end
    a_out_ready = 1; b_out_ready = 1;
    budget = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_in_valid || b_in_valid) && budget < 200) begin
      sample();
      advance();
      if (acc_a) a_in_valid = 0;
      if (acc_b) b_in_valid = 0;
      budget++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0 || a_in_valid || b_in_valid || sent_a != 25 || sent_b != 25) begin
      errors++;
      $display("FAIL random_drain got pending a=%0d b=%0d sent a=%0d b=%0d, expected 0 0 25 25",
               qa.size(), qb.size(), sent_a, sent_b);
    end
  endtask

  initial begin
    or_a = '0; or_b = '0;
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_onehot_split
